// File: rtl/risc16_mmio_pkg.sv
// ---------------------------------------------------------------------------
// risc16_mmio_pkg
// Shared definitions for the risc16 memory-mapped peripheral window
// (0xFF00-0xFF0F): register offsets (word index daddr[3:1]), STATUS and
// TCTRL bit positions, the UART TX state type and a byte-lane merge helper.
// ---------------------------------------------------------------------------
package risc16_mmio_pkg;

    // Register offsets, selected by daddr[3:1]
    localparam logic [2:0] OFS_TXDATA = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd1;
    localparam logic [2:0] OFS_COUNT  = 3'd2;
    localparam logic [2:0] OFS_CMP    = 3'd3;
    localparam logic [2:0] OFS_TCTRL  = 3'd4;

    // STATUS bit positions
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    // TCTRL bit positions
    localparam int TC_EN   = 0;
    localparam int TC_IE   = 1;
    localparam int TC_FLAG = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // dwe0 strobes the high byte lane, dwe1 the low byte lane.
    function automatic logic [15:0] merge_lanes(input logic [15:0] cur,
                                                input logic [15:0] wdata,
                                                input logic        we_hi,
                                                input logic        we_lo);
        return {we_hi ? wdata[15:8] : cur[15:8],
                we_lo ? wdata[7:0]  : cur[7:0]};
    endfunction

endpackage

// File: rtl/risc16_mmio_fifo.sv
// ---------------------------------------------------------------------------
// risc16_mmio_fifo
// Synchronous byte FIFO used as the UART transmit buffer.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and byte; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry (combinational, valid when not empty)
//   full/empty : occupancy flags
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module risc16_mmio_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full with a simultaneous pop, the write lands in the slot being
    // vacated; the popped value is taken from dout before this edge.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/risc16_mmio.sv
// ---------------------------------------------------------------------------
// risc16_mmio
// Peripheral window on the risc16ba data port at 0xFF00-0xFF0F: a buffered
// 8N1 UART transmitter and an optional compare-match timer.
//
// Registers (daddr[3:1], daddr[0] ignored):
//   0xFF00 TXDATA  W   push one byte (dwe1 -> ddout[7:0], dwe0 only -> ddout[15:8])
//   0xFF02 STATUS  R/W bit0 full, bit1 empty, bit2 busy, bit3 overflow (write 1 clears)
//   0xFF04 COUNT   R/W timer count
//   0xFF06 CMP     R/W compare value
//   0xFF08 TCTRL   R/W bit0 en, bit1 ie, bit2 flag (write 1 clears)
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   daddr, ddout     : CPU data address and write data
//   doe              : CPU read strobe
//   dwe0, dwe1       : byte write strobes for [15:8] and [7:0]
//   sel              : address falls in the window (combinational)
//   rdata            : combinational read data, 0 unless sel && doe
//   txd              : UART serial output, idle high
//   irq              : timer interrupt, flag & ie
//
// Configuration macro RISC16_MMIO_TIMER_EN: when defined the timer is built;
// otherwise COUNT/CMP/TCTRL read 0, ignore writes, and irq is 0.
//
// TX state table:
//   IDLE  | line high; pops the FIFO when it holds data
//   START | start bit (0) for CLK_DIV cycles
//   DATA  | 8 data bits LSB first, CLK_DIV cycles each
//   STOP  | stop bit (1) for CLK_DIV cycles, then back to IDLE
// ---------------------------------------------------------------------------
module risc16_mmio
    import risc16_mmio_pkg::*;
#(
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe0,
    input  logic        dwe1,
    output logic        sel,
    output logic [15:0] rdata,
    output logic        txd,
    output logic        irq
);

    localparam logic [15:0] BIT_RELOAD = CLK_DIV - 16'd1;

    // ---------------------------------------------------------------- decode
    logic [2:0] ofs;
    logic       wr_any;
    logic       wr_txdata;
    logic       wr_status;
    logic       unused_addr_bit;

    assign sel       = (daddr[15:4] == 12'hFF0);
    assign ofs       = daddr[3:1];
    assign wr_any    = sel && (dwe0 || dwe1);
    assign wr_txdata = wr_any && (ofs == OFS_TXDATA);
    assign wr_status = wr_any && (ofs == OFS_STATUS);

    // Byte accesses to either half of a register select the same register.
    assign unused_addr_bit = daddr[0];

    // ------------------------------------------------------------------ FIFO
    logic [7:0] push_byte;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    // A word store carries the byte in the low lane, same as an SB to the odd address.
    assign push_byte = dwe1 ? ddout[7:0] : ddout[15:8];

    risc16_mmio_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (push_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ----------------------------------------------------------- UART TX FSM
    tx_state_t   state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_done;
    logic        overflow;

    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign bit_done = (bit_cnt == 16'd0);

    // txd is registered so the pin never glitches on state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            txd     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state   <= START;
                        shreg   <= fifo_dout;
                        bit_cnt <= BIT_RELOAD;
                        txd     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_cnt <= BIT_RELOAD;
                        bit_idx <= 3'd0;
                        txd     <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    // A push into a full FIFO is only lost when no pop frees a slot that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (wr_status && dwe1 && ddout[ST_OVF]) begin
            overflow <= 1'b0;
        end
    end

    logic [15:0] status_rd;

    always_comb begin
        status_rd           = 16'h0000;
        status_rd[ST_FULL]  = fifo_full;
        status_rd[ST_EMPTY] = fifo_empty;
        status_rd[ST_BUSY]  = (state != IDLE);
        status_rd[ST_OVF]   = overflow;
    end

    // ----------------------------------------------------------------- timer
    logic [15:0] count_rd;
    logic [15:0] cmp_rd;
    logic [15:0] tctrl_rd;

`ifdef RISC16_MMIO_TIMER_EN
    logic [15:0] count;
    logic [15:0] cmp;
    logic        en;
    logic        ie;
    logic        flag;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_tctrl;
    logic        match;

    assign wr_count = wr_any && (ofs == OFS_COUNT);
    assign wr_cmp   = wr_any && (ofs == OFS_CMP);
    assign wr_tctrl = wr_any && (ofs == OFS_TCTRL);
    assign match    = en && (count == cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'h0000;
            cmp   <= 16'h0000;
            en    <= 1'b0;
            ie    <= 1'b0;
            flag  <= 1'b0;
        end else begin
            // CPU write beats both the match reload and the increment.
            if (wr_count) begin
                count <= merge_lanes(count, ddout, dwe0, dwe1);
            end else if (match) begin
                count <= 16'h0000;
            end else if (en) begin
                count <= count + 16'd1;
            end

            if (wr_cmp) cmp <= merge_lanes(cmp, ddout, dwe0, dwe1);

            if (wr_tctrl && dwe1) begin
                en <= ddout[TC_EN];
                ie <= ddout[TC_IE];
            end

            // A match masked by a COUNT write does not set the flag; a real
            // match outranks a simultaneous software clear.
            if (match && !wr_count) begin
                flag <= 1'b1;
            end else if (wr_tctrl && dwe1 && ddout[TC_FLAG]) begin
                flag <= 1'b0;
            end
        end
    end

    always_comb begin
        tctrl_rd          = 16'h0000;
        tctrl_rd[TC_EN]   = en;
        tctrl_rd[TC_IE]   = ie;
        tctrl_rd[TC_FLAG] = flag;
    end

    assign count_rd = count;
    assign cmp_rd   = cmp;
    assign irq      = flag & ie;
`else
    assign count_rd = 16'h0000;
    assign cmp_rd   = 16'h0000;
    assign tctrl_rd = 16'h0000;
    assign irq      = 1'b0;
`endif

    // ------------------------------------------------------------- read mux
    always_comb begin
        rdata = 16'h0000;
        if (sel && doe) begin
            case (ofs)
                OFS_STATUS: rdata = status_rd;
                OFS_COUNT:  rdata = count_rd;
                OFS_CMP:    rdata = cmp_rd;
                OFS_TCTRL:  rdata = tctrl_rd;
                default:    rdata = 16'h0000;
            endcase
        end
    end

endmodule
